// File: rtl/mips_mc_ctrl_if.sv
// rtl/mips_mc_ctrl_if.sv - control/handshake bundle between the multi-cycle sequencer and the MIPS datapath
interface mips_mc_ctrl_if #(
  parameter int CNT_W = 32
);
  logic             Run;
  logic [31:0]      Ins;
  logic             Zero;
  logic             IMemAck;
  logic             DMemAck;
  logic             IMemReq;
  logic             DMemReq;
  logic             MemWrite;
  logic             IRWrite;
  logic             PCWrite;
  logic [1:0]       PCSrc;
  logic             RegWrite;
  logic [1:0]       RegDst;
  logic [1:0]       WdSel;
  logic             ALUSrcB;
  logic [1:0]       ALUOp;
  logic             Retire;
  logic             Illegal;
  logic [2:0]       State;
  logic [CNT_W-1:0] InstCount;

  modport slave (
    input  Run, Ins, Zero, IMemAck, DMemAck,
    output IMemReq, DMemReq, MemWrite, IRWrite, PCWrite, PCSrc, RegWrite,
           RegDst, WdSel, ALUSrcB, ALUOp, Retire, Illegal, State, InstCount
  );

  modport master (
    output Run, Ins, Zero, IMemAck, DMemAck,
    input  IMemReq, DMemReq, MemWrite, IRWrite, PCWrite, PCSrc, RegWrite,
           RegDst, WdSel, ALUSrcB, ALUOp, Retire, Illegal, State, InstCount
  );
endinterface

// File: rtl/mips_mc_ctrl.sv
// rtl/mips_mc_ctrl.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with retired-instruction counter
module mips_mc_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  mips_mc_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count;

  logic [5:0] opcode, funct;
  logic       is_r, r_ok, is_lw, is_sw, is_beq, is_addi, is_j, is_jal, legal;
  logic       unused_ins;

  logic       imem_req, dmem_req, mem_write, ir_write, pc_write, reg_write;
  logic       alu_src_b, retire, illegal;
  logic [1:0] pc_src, reg_dst, wd_sel, alu_op;

  assign opcode     = bus.Ins[31:26];
  assign funct      = bus.Ins[5:0];
  assign unused_ins = ^bus.Ins[25:6];

  assign is_r    = (opcode == 6'h00);
  assign r_ok    = (funct == 6'h20) || (funct == 6'h22) || (funct == 6'h24) ||
                   (funct == 6'h25) || (funct == 6'h2A);
  assign is_lw   = (opcode == 6'h23);
  assign is_sw   = (opcode == 6'h2B);
  assign is_beq  = (opcode == 6'h04);
  assign is_addi = (opcode == 6'h08);
  assign is_j    = (opcode == 6'h02);
  assign is_jal  = (opcode == 6'h03);
  assign legal   = (is_r && r_ok) || is_lw || is_sw || is_beq || is_addi || is_j || is_jal;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= S_FETCH;
      count <= '0;
    end else begin
      state <= state_nxt;
      if (retire) count <= count + CNT_W'(1);
    end
  end

  // Every output is forced low while RST is held, so nothing escapes an aborted instruction.
  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    mem_write = 1'b0;
    ir_write  = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'b00;
    reg_write = 1'b0;
    reg_dst   = 2'b00;
    wd_sel    = 2'b00;
    alu_src_b = 1'b0;
    alu_op    = 2'b00;
    retire    = 1'b0;
    illegal   = 1'b0;
    if (RST) begin
      case (state)
        S_FETCH: begin
          imem_req = bus.Run;
          if (bus.Run && bus.IMemAck) begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            state_nxt = S_DECODE;
          end
        end
        S_DECODE: begin
          if (!legal) begin
            state_nxt = S_TRAP;
          end else if (is_j || is_jal) begin
            pc_write  = 1'b1;
            pc_src    = 2'b10;
            retire    = 1'b1;
            state_nxt = S_FETCH;
            if (is_jal) begin
              reg_write = 1'b1;
              reg_dst   = 2'b10;
              wd_sel    = 2'b10;
            end
          end else begin
            state_nxt = S_EXEC;
          end
        end
        S_EXEC: begin
          if (is_r) begin
            alu_op    = 2'b10;
            state_nxt = S_WB;
          end else if (is_addi) begin
            alu_src_b = 1'b1;
            state_nxt = S_WB;
          end else if (is_lw || is_sw) begin
            alu_src_b = 1'b1;
            state_nxt = S_MEM;
          end else if (is_beq) begin
            alu_op    = 2'b01;
            pc_write  = bus.Zero;
            pc_src    = 2'b01;
            retire    = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_TRAP;
          end
        end
        S_MEM: begin
          dmem_req  = 1'b1;
          mem_write = is_sw;
          if (bus.DMemAck) begin
            if (is_sw) begin
              retire    = 1'b1;
              state_nxt = S_FETCH;
            end else begin
              state_nxt = S_WB;
            end
          end
        end
        S_WB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
          state_nxt = S_FETCH;
          if (is_r)       reg_dst = 2'b01;
          else if (is_lw) wd_sel  = 2'b01;
        end
        S_TRAP: begin
          illegal = 1'b1;
        end
        default: state_nxt = S_FETCH;
      endcase
    end
  end

  assign bus.IMemReq   = imem_req;
  assign bus.DMemReq   = dmem_req;
  assign bus.MemWrite  = mem_write;
  assign bus.IRWrite   = ir_write;
  assign bus.PCWrite   = pc_write;
  assign bus.PCSrc     = pc_src;
  assign bus.RegWrite  = reg_write;
  assign bus.RegDst    = reg_dst;
  assign bus.WdSel     = wd_sel;
  assign bus.ALUSrcB   = alu_src_b;
  assign bus.ALUOp     = alu_op;
  assign bus.Retire    = retire;
  assign bus.Illegal   = illegal;
  assign bus.State     = state;
  assign bus.InstCount = count;

endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Multi-cycle sequencer for the MIPS core, replacing the implicit single-cycle sequencing of the top-level join of IF/ID/EX/DM.
- Steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Drives the PC/IR/register-file/data-memory enables and mux selects.
- Stalls on a request/acknowledge handshake to instruction and data memory; counts retired instructions.

Parameters:
CNT_W, 32, width of retired-instruction counter InstCount

Ports:
CLK  input  1  clock, rising edge
RST  input  1  asynchronous active-low reset
Run  input  1  1 = permit new instruction fetch
Ins  input  32  current instruction word from IR (opcode Ins[31:26], funct Ins[5:0])
Zero  input  1  ALU zero flag from EX
IMemAck  input  1  instruction memory data valid
DMemAck  input  1  data memory access complete
IMemReq  output  1  instruction fetch request
DMemReq  output  1  data memory request
MemWrite  output  1  data memory write (valid with DMemReq)
IRWrite  output  1  load instruction register
PCWrite  output  1  load PC
PCSrc  output  2  00 PC+4, 01 branch target, 10 jump target
RegWrite  output  1  register file write enable
RegDst  output  2  00 rt, 01 rd, 10 r31
WdSel  output  2  00 ALU result, 01 memory data, 10 nextPC
ALUSrcB  output  1  0 Rdata2, 1 Ed32
ALUOp  output  2  00 add, 01 sub, 10 funct-decoded
Retire  output  1  one-cycle pulse at last cycle of each instruction
Illegal  output  1  sticky; unsupported opcode/funct trapped
State  output  3  0 FETCH, 1 DECODE, 2 EXEC, 3 MEM, 4 WB, 5 TRAP
InstCount  output  CNT_W  retired-instruction count, wraps modulo 2^CNT_W

Behaviour:
- Decoded instructions: R (opcode 0x00; funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt), LW 0x23, SW 0x2B, BEQ 0x04, ADDI 0x08, J 0x02, JAL 0x03. Anything else is illegal.
- State register and InstCount are clocked. All other outputs are combinational from State, Ins, Zero and the Ack inputs. Any output not listed for a state is 0.
- RST low: State=FETCH, InstCount=0, Illegal=0 immediately, independent of CLK. All outputs are held 0 while RST is low.
- FETCH:
  - IMemReq=Run.
  - IMemAck=1 with Run=1: IRWrite=1, PCWrite=1, PCSrc=00, next DECODE.
  - Otherwise stay in FETCH.
  - IMemAck while Run=0 is ignored.
- DECODE (always 1 cycle):
  - J: PCWrite=1, PCSrc=10, Retire, next FETCH.
  - JAL: J actions plus RegWrite=1, RegDst=10, WdSel=10, next FETCH.
  - Illegal opcode or R funct: next TRAP.
  - Otherwise next EXEC.
- EXEC (1 cycle):
  - R: ALUOp=10, ALUSrcB=0, next WB.
  - ADDI/LW/SW: ALUOp=00, ALUSrcB=1; ADDI next WB, LW/SW next MEM.
  - BEQ: ALUOp=01, ALUSrcB=0; PCWrite=Zero, PCSrc=01, Retire, next FETCH.
- MEM:
  - DMemReq=1; MemWrite=1 for SW. Hold all outputs stable until DMemAck.
  - On DMemAck: SW Retires and goes to FETCH; LW goes to WB.
- WB (1 cycle):
  - RegWrite=1, Retire, next FETCH.
  - R: RegDst=01, WdSel=00. ADDI: RegDst=00, WdSel=00. LW: RegDst=00, WdSel=01.
- TRAP: Illegal=1; all enables 0; stays in TRAP until RST.
- InstCount increments by 1 on every clock edge where Retire=1. Rollover from all-ones is to 0.
- Cycle counts with zero-wait memory: J/JAL 2; BEQ 3; R/ADDI/SW 4; LW 5. Each memory wait cycle adds 1.
- Ack arriving in the same cycle as Req is legal and counts as zero-wait.
- Acks outside their own state (IMemAck outside FETCH, DMemAck outside MEM) are ignored.
- Reset asserted mid-instruction aborts it: no partial Retire, no PCWrite or RegWrite after RST falls.
- Run deasserted outside FETCH does not stall; the current instruction completes, then FETCH idles.

Test Plan:
- Run=1, zero-wait, Ins=0x00851020 (add $2,$4,$5) -> States 0,1,2,4; RegWrite=1 with RegDst=01 in WB; InstCount=1 after 4 cycles.
- LW Ins=0x8C820004 with DMemAck delayed 3 cycles -> MEM held 4 cycles with DMemReq=1, MemWrite=0; WB WdSel=01, RegDst=00; total 8 cycles.
- BEQ Ins=0x10850003 with Zero=1, then Zero=0 -> PCWrite=1, PCSrc=01 in EXEC for the first; PCWrite=0 for the second; Retire both times.
- JAL Ins=0x0C000010 -> DECODE asserts PCWrite, PCSrc=10, RegWrite, RegDst=10, WdSel=10; 2 cycles total.
- Ins=0xFC000000 -> TRAP, Illegal=1, all enables 0 for 20 cycles; RST low -> State=0, Illegal=0 without a clock edge.
- Preload InstCount near max (CNT_W=4, 16 retires) -> wraps to 0. RST low during MEM of SW -> no MemWrite after reset, InstCount=0.
